// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot/index grant and release-driven pointer rotation.
// Optional forced release after MAX_HOLD cycles is compiled in with `define RR_ARB_TIMEOUT_EN.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [7:0] iReq,
    input  logic       iDone,
    output logic [7:0] oGnt,
    output logic [2:0] oGntIdx,
    output logic       oValid,
    output logic       oTimeout
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] ptr_q,   ptr_d;
    logic [7:0] gnt_q,   gnt_d;
    logic [2:0] idx_q,   idx_d;
    logic       valid_q, valid_d;

    logic       win_found;
    logic [2:0] win_idx;
    logic       normal_rel;
    logic       hold_hit;
    logic       release_now;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter8: MAX_HOLD must be within 1..255");
    end

    // First set request bit at or after the rotating pointer.
    always_comb begin
        logic [2:0] cand;
        // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 0; k < 8; k++) begin
            cand = ptr_q + 3'(k);
            if (!win_found && iReq[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // iDone and withdrawal together are still a single release.
    assign normal_rel  = iDone | ~iReq[idx_q];
    assign release_now = normal_rel | hold_hit;

`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    assign hold_hit = (state_q == ST_GRANT) && (hold_q == 8'(MAX_HOLD - 1));
    assign hold_d   = (state_q == ST_GRANT) ? hold_q + 8'd1 : 8'd0;

    // The pulse is raised only when the timer alone caused the release.
    always_comb begin
        timeout_d = 1'b0;
        if (state_q == ST_GRANT && release_now) begin
            timeout_d = hold_hit & ~normal_rel;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign oTimeout = timeout_q;
`else
    assign hold_hit = 1'b0;
    assign oTimeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (win_found)   state_d = ST_GRANT;
            ST_GRANT: if (release_now) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    gnt_d   = 8'd1 << win_idx;
                    idx_d   = win_idx;
                    valid_d = 1'b1;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    gnt_d   = 8'd0;
                    idx_d   = 3'd0;
                    valid_d = 1'b0;
                    ptr_d   = idx_q + 3'd1;
                end
            end
            default: begin
                gnt_d   = 8'd0;
                idx_d   = 3'd0;
                valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples the pre-edge values.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 3'd0;
            gnt_q   <= 8'd0;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign oGnt    = gnt_q;
    assign oGntIdx = idx_q;
    assign oValid  = valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: a grant-owner model checked every cycle plus literal spot checks.
// Built with or without RR_ARB_TIMEOUT_EN; the DUT runs with MAX_HOLD=4.
module tb_rr_arbiter8;

    localparam int MAX_HOLD = 4;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       iClk;
    logic       iRst;
    logic [7:0] iReq;
    logic       iDone;
    logic [7:0] oGnt;
    logic [2:0] oGntIdx;
    logic       oValid;
    logic       oTimeout;

    int n_checks = 0;
    int n_pass   = 0;

    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iReq     (iReq),
        .iDone    (iDone),
        .oGnt     (oGnt),
        .oGntIdx  (oGntIdx),
        .oValid   (oValid),
        .oTimeout (oTimeout)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: who owns the resource (-1 = nobody), where the search starts, how long held.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_to    = 1'b0;

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    always @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            m_owner <= -1;
            m_ptr   <= 0;
            m_hold  <= 0;
            m_to    <= 1'b0;
        end else if (m_owner < 0) begin
            m_to    <= 1'b0;
            m_hold  <= 0;
            m_owner <= pick(iReq, m_ptr);
        end else if (iDone || !iReq[m_owner]) begin
            m_owner <= -1;
            m_ptr   <= (m_owner + 1) % 8;
            m_to    <= 1'b0;
        end else if (TO_EN && m_hold == MAX_HOLD - 1) begin
            m_owner <= -1;
            m_ptr   <= (m_owner + 1) % 8;
            m_to    <= 1'b1;
        end else begin
            m_hold  <= m_hold + 1;
        end
    end

    always @(negedge iClk) begin
        if (!iRst) begin
            check("model_gnt",   {24'd0, oGnt},    (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
            check("model_idx",   {29'd0, oGntIdx}, (m_owner < 0) ? 32'd0 : 32'(m_owner));
            check("model_valid", {31'd0, oValid},  {31'd0, m_owner >= 0});
            check("model_tout",  {31'd0, oTimeout}, {31'd0, m_to});
        end
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    initial begin
        iRst  = 1'b1;
        iReq  = 8'h00;
        iDone = 1'b0;
        repeat (2) tick();
        check("rst_gnt",   {24'd0, oGnt},    32'h00);
        check("rst_idx",   {29'd0, oGntIdx}, 32'd0);
        check("rst_valid", {31'd0, oValid},  32'd0);
        check("rst_tout",  {31'd0, oTimeout}, 32'd0);
        iRst = 1'b0;

        // Two requesters at the ends of the ring; pointer wraps 7 -> 0.
        iReq = 8'h81;
        tick();
        check("t1_first_gnt", {24'd0, oGnt},    32'h01);
        check("t1_first_idx", {29'd0, oGntIdx}, 32'd0);
        repeat (2) tick();
        iDone = 1'b1;
        tick();
        check("t1_gap_valid", {31'd0, oValid}, 32'd0);
        iDone = 1'b0;
        tick();
        check("t1_second_gnt", {24'd0, oGnt},    32'h80);
        check("t1_second_idx", {29'd0, oGntIdx}, 32'd7);
        tick();
        iDone = 1'b1;
        tick();
        check("t1_rel_gnt", {24'd0, oGnt}, 32'h00);
        iDone = 1'b0;
        tick();
        check("t1_wrap_gnt", {24'd0, oGnt}, 32'h01);
        iReq = 8'h00;
        tick();
        check("t1_withdraw_valid", {31'd0, oValid}, 32'd0);

        // All requesting, iDone held: strict rotation with one idle cycle between grants.
        iRst = 1'b1;
        tick();
        iRst  = 1'b0;
        iReq  = 8'hFF;
        iDone = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("t2_idx",   {29'd0, oGntIdx}, 32'(i % 8));
            check("t2_gnt",   {24'd0, oGnt},    32'd1 << (i % 8));
            tick();
            check("t2_gap",   {31'd0, oValid},  32'd0);
        end
        iDone = 1'b0;
        iReq  = 8'h00;
        tick();

        // Withdrawal releases and advances the pointer past the holder.
        iReq = 8'h08;
        tick();
        check("t3_idx3", {29'd0, oGntIdx}, 32'd3);
        iReq = 8'h00;
        tick();
        check("t3_rel_gnt",   {24'd0, oGnt},   32'h00);
        check("t3_rel_valid", {31'd0, oValid}, 32'd0);
        iReq = 8'h18;
        tick();
        check("t3_idx4", {29'd0, oGntIdx}, 32'd4);
        iReq = 8'h00;
        tick();

        // Asynchronous reset in the middle of a grant.
        iReq = 8'h20;
        tick();
        check("t4_idx5", {29'd0, oGntIdx}, 32'd5);
        #2;
        iRst = 1'b1;
        #1;
        check("t4_async_gnt",   {24'd0, oGnt},    32'h00);
        check("t4_async_idx",   {29'd0, oGntIdx}, 32'd0);
        check("t4_async_valid", {31'd0, oValid},  32'd0);
        tick();
        iRst = 1'b0;
        iReq = 8'h21;
        tick();
        check("t4_ptr0_idx", {29'd0, oGntIdx}, 32'd0);
        iReq = 8'h00;
        tick();

        // Single requester held with no iDone.
        iReq = 8'h04;
        tick();
        check("t5_idx2", {29'd0, oGntIdx}, 32'd2);
        if (TO_EN) begin
            repeat (3) begin
                tick();
                check("t5_held", {24'd0, oGnt}, 32'h04);
            end
            tick();
            check("t5_forced_gnt",  {24'd0, oGnt},     32'h00);
            check("t5_forced_tout", {31'd0, oTimeout}, 32'd1);
            tick();
            check("t5_regrant_idx",  {29'd0, oGntIdx},  32'd2);
            check("t5_regrant_tout", {31'd0, oTimeout}, 32'd0);
            // iDone lands on the very edge the timer would fire.
            repeat (3) tick();
            iDone = 1'b1;
            tick();
            check("t6_rel_valid", {31'd0, oValid},   32'd0);
            check("t6_rel_tout",  {31'd0, oTimeout}, 32'd0);
            iDone = 1'b0;
        end else begin
            repeat (110) tick();
            check("t5_still_gnt",  {24'd0, oGnt},     32'h04);
            check("t5_still_tout", {31'd0, oTimeout}, 32'd0);
            iDone = 1'b1;
            tick();
            check("t5_done_valid", {31'd0, oValid}, 32'd0);
            iDone = 1'b0;
        end
        iReq = 8'h00;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one downstream resource (for example an encoder83 datapath or a shared bus) among 8 requesters.
- Samples a request vector, grants exactly one requester, and holds the grant until the requester releases it.
- Outputs the grant as one-hot plus a 3-bit encoded index, so downstream logic can use either form directly.
- Sits between requesting units and the shared resource. Fairness comes from a rotating priority pointer.

Parameters:
- MAX_HOLD, 16, cycles a grant may stay in GRANT before forced release (used only with RR_ARB_TIMEOUT_EN); legal range 1..255.

Ports:
- iClk  input  1  clock, rising edge active
- iRst  input  1  asynchronous, active-high reset
- iReq  input  8  request vector; bit n = requester n wants the resource
- iDone  input  1  release strobe from the current grant holder
- oGnt  output  8  one-hot grant; all zero when no grant
- oGntIdx  output  3  binary index of the granted requester; 0 when no grant
- oValid  output  1  1 while a grant is active (oGnt != 0)
- oTimeout  output  1  one-cycle pulse on forced release; constant 0 without the macro

Behaviour:
- Reset (async, iRst=1): state=IDLE, ptr=0, oGnt=8'h00, oGntIdx=3'd0, oValid=0, oTimeout=0, hold counter=0.
- All outputs are registered. There is no combinational path from iReq or iDone to any output.
- States: IDLE, GRANT.
- IDLE:
  - If iReq==0 at a rising edge, stay in IDLE.
  - Otherwise, at that edge select the first set bit in search order ptr, ptr+1, …, ptr+7 (mod 8).
  - Load oGnt/oGntIdx with the winner, set oValid=1, clear the hold counter, go to GRANT.
  - Latency: a request seen at edge k gives a grant visible after edge k.
- GRANT:
  - Hold oGnt/oGntIdx stable and increment the hold counter each cycle.
  - Release condition at an edge: iDone=1, or iReq[oGntIdx]=0 (requester withdrew), or timeout (macro only).
  - On release: clear oGnt/oGntIdx/oValid, set ptr = oGntIdx+1 (3-bit wrap, so 7 -> 0), go to IDLE.
- Minimum one IDLE cycle between consecutive grants. Worst-case wait for any continuously requesting line is 7 grants.
- Simultaneous events:
  - iDone and withdrawal in the same cycle count as a single release.
  - A new request arriving during GRANT is ignored until the next IDLE.
  - iDone in IDLE is ignored.
- Reset during GRANT clears everything immediately, without waiting for a clock edge. ptr returns to 0.
- oGntIdx always equals the binary encoding of oGnt.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- Defined:
  - When the hold counter reaches MAX_HOLD-1 in GRANT without a release, the next edge forces a release.
  - Forced release uses the same ptr update as a normal release and pulses oTimeout=1 for exactly that one IDLE cycle.
  - If iDone coincides with the timeout edge, it is a normal release and oTimeout stays 0.
- Not defined: no counter logic is synthesized, oTimeout is tied 0, and a grant is held indefinitely.

Test Plan:
1. Reset then iReq=8'h81, iDone pulsed 1 cycle after 3 cycles of grant:
   - first grant oGnt=8'h01, oGntIdx=0;
   - after release and 1 IDLE cycle, oGnt=8'h80, oGntIdx=7;
   - after the next release, ptr wraps to 0 and bit 0 wins again.
2. iReq=8'hFF held, iDone pulsed each GRANT cycle:
   - grant sequence idx 0,1,2,…,7,0, with oValid=0 for exactly 1 cycle between grants.
3. Grant to idx 3 (iReq=8'h08), then drop iReq to 8'h00 without iDone:
   - next edge oGnt=8'h00, oValid=0, ptr=4;
   - subsequent iReq=8'h18 grants idx 4.
4. iRst asserted mid-GRANT (idx 5) between clock edges:
   - outputs go to 0 immediately;
   - after release, iReq=8'h21 grants idx 0 (ptr reset).
5. With RR_ARB_TIMEOUT_EN and MAX_HOLD=4, iReq=8'h04 held, no iDone:
   - grant held 4 cycles, then oGnt=0 and oTimeout=1 for one cycle;
   - regrant idx 2 (only requester).
   - Without the macro, the grant holds for more than 100 cycles and oTimeout stays 0.
6. iDone in the same cycle as the timeout edge (macro on):
   - normal release, oTimeout stays 0.
